// File: rtl/imul_arbiter.sv
// Round-robin arbiter that shares one iterative 8x32 multiplier among N_REQ requesters,
// with a zero-operand bypass and a commit timeout that returns an error response.
module imul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int A_W     = 8,
    parameter int B_W     = 32,
    parameter int P_W     = 40,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_val,
    output logic [N_REQ-1:0]       req_rdy,
    input  logic [N_REQ*A_W-1:0]   req_A,
    input  logic [N_REQ*B_W-1:0]   req_B,
    output logic [N_REQ-1:0]       resp_val,
    input  logic [N_REQ-1:0]       resp_rdy,
    output logic [P_W-1:0]         resp_P,
    output logic                   resp_err,
    output logic [A_W-1:0]         mul_A,
    output logic [B_W-1:0]         mul_B,
    output logic                   mul_val_op,
    input  logic                   mul_commit,
    input  logic [P_W-1:0]         mul_P,
    output logic                   busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   gnt;
    logic [CW-1:0]   cnt;
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW:0]     idx;
    logic [A_W-1:0]  a_sel;
    logic [B_W-1:0]  b_sel;

    // Search from the round-robin pointer upward, wrapping, for the first active request.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N_REQ))
                idx = idx - (IW+1)'(N_REQ);
            if (!found && req_val[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    assign a_sel = req_A[pick*A_W +: A_W];
    assign b_sel = req_B[pick*B_W +: B_W];

    // Gating on reset keeps req_rdy low while the block is held in reset.
    assign req_rdy  = (reset && state == IDLE && found) ? (N_REQ'(1) << pick) : '0;
    assign resp_val = (state == RESP) ? (N_REQ'(1) << gnt) : '0;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr         <= '0;
            gnt        <= '0;
            cnt        <= '0;
            resp_P     <= '0;
            resp_err   <= 1'b0;
            mul_A      <= '0;
            mul_B      <= '0;
            mul_val_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mul_val_op <= 1'b0;
                    if (found) begin
                        mul_A <= a_sel;
                        mul_B <= b_sel;
                        gnt   <= pick;
                        if (a_sel == '0 || b_sel == '0) begin
                            resp_P   <= '0;
                            resp_err <= 1'b0;
                            state    <= RESP;
                        end else begin
                            mul_val_op <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mul_val_op <= 1'b0;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A commit landing on the final timeout cycle still counts as success.
                    if (mul_commit) begin
                        resp_P   <= mul_P;
                        resp_err <= 1'b0;
                        state    <= RESP;
                    end else if (cnt == CW'(TIMEOUT-1)) begin
                        resp_P   <= '0;
                        resp_err <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_rdy[gnt]) begin
                        rr    <= (gnt == IW'(N_REQ-1)) ? '0 : gnt + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imul_arbiter.sv
// Directed bench for imul_arbiter: a vector table of single transactions plus
// hand-written sequences for back-pressure, late commit, reset and round-robin order.
module tb_imul_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_val;
    logic [3:0]   req_rdy;
    logic [31:0]  req_A;
    logic [127:0] req_B;
    logic [3:0]   resp_val;
    logic [3:0]   resp_rdy;
    logic [39:0]  resp_P;
    logic         resp_err;
    logic [7:0]   mul_A;
    logic [31:0]  mul_B;
    logic         mul_val_op;
    logic         mul_commit;
    logic [39:0]  mul_P = '0;
    logic         busy;

    logic model_commit = 1'b0;
    logic manual_commit = 1'b0;
    int   mul_lat = 0;
    int   vop_count = 0;
    int   compared = 0;
    int   mismatched = 0;

    assign mul_commit = model_commit | manual_commit;

    imul_arbiter #(.N_REQ(4), .A_W(8), .B_W(32), .P_W(40), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_A(req_A), .req_B(req_B),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_P(resp_P), .resp_err(resp_err),
        .mul_A(mul_A), .mul_B(mul_B), .mul_val_op(mul_val_op),
        .mul_commit(mul_commit), .mul_P(mul_P), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [31:0] b;
        int          lat;
        logic [39:0] p;
        logic        err;
        int          k;
        int          vops;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Multiplier model: commits the product mul_lat cycles after the start pulse; 0 means never.
    always begin
        logic [39:0] ea, eb;
        int n;
        @(negedge clk);
        if (reset && mul_val_op === 1'b1) begin
            vop_count++;
            if (mul_lat > 0) begin
                ea = {32'b0, mul_A};
                eb = {8'b0, mul_B};
                n  = mul_lat;
                repeat (n) @(posedge clk);
                #1;
                model_commit = 1'b1;
                mul_P = ea * eb;
                @(posedge clk);
                #1;
                model_commit = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("resp_val_onehot0", 64'($onehot0(resp_val)), 64'(1));
            if (busy) checkOutput("req_rdy_while_busy", 64'(req_rdy), 64'(0));
        end
    end

    task automatic applyStimulus(input vec_t v);
        logic [3:0] oh;
        int k;
        int v0;
        oh = 4'b1 << v.idx;
        mul_lat = v.lat;
        v0 = vop_count;
        req_A = '0;
        req_B = '0;
        req_A[v.idx*8 +: 8]   = v.a;
        req_B[v.idx*32 +: 32] = v.b;
        req_val = oh;
        #1;
        checkOutput("req_rdy_grant", 64'(req_rdy), 64'(oh));
        tick();
        req_val = '0;
        k = 0;
        while (resp_val == '0 && k < 200) begin
            tick();
            k++;
        end
        checkOutput("latency", 64'(k), 64'(v.k));
        checkOutput("resp_val", 64'(resp_val), 64'(oh));
        checkOutput("resp_P", 64'(resp_P), 64'(v.p));
        checkOutput("resp_err", 64'(resp_err), 64'(v.err));
        checkOutput("val_op_pulses", 64'(vop_count - v0), 64'(v.vops));
        resp_rdy = 4'b1 << ((v.idx + 1) % 4);
        tick();
        checkOutput("other_rdy_ignored", 64'(resp_val), 64'(oh));
        resp_rdy = oh;
        tick();
        resp_rdy = '0;
        checkOutput("busy_after_accept", 64'(busy), 64'(0));
        checkOutput("resp_val_after_accept", 64'(resp_val), 64'(0));
    endtask

    initial begin
        logic [3:0]  rr_exp;
        logic [39:0] rr_p[4];
        int k;
        int g;

        vecs[0] = '{0, 8'd3,    32'd5,         8,  40'd15,           1'b0, 9,  1};
        vecs[1] = '{1, 8'hFF,   32'hFFFFFFFF,  2,  40'hFE_FFFF_FF01, 1'b0, 3,  1};
        vecs[2] = '{2, 8'h00,   32'h1234,      2,  40'd0,            1'b0, 0,  0};
        vecs[3] = '{3, 8'h07,   32'h0,         2,  40'd0,            1'b0, 0,  0};
        vecs[4] = '{2, 8'h10,   32'h1000,      1,  40'h1_0000,       1'b0, 2,  1};
        vecs[5] = '{1, 8'h80,   32'h8000_0000, 3,  40'h40_0000_0000, 1'b0, 4,  1};
        vecs[6] = '{0, 8'h02,   32'h3,         0,  40'd0,            1'b1, 65, 1};
        vecs[7] = '{3, 8'h04,   32'h5,         64, 40'd20,           1'b0, 65, 1};

        rr_p[0] = 40'd200;
        rr_p[1] = 40'd600;
        rr_p[2] = 40'd1200;
        rr_p[3] = 40'd2000;

        reset = 1'b0;
        req_val = '0;
        req_A = '0;
        req_B = '0;
        resp_rdy = '0;
        tick();
        tick();
        checkOutput("rst_req_rdy", 64'(req_rdy), 64'(0));
        checkOutput("rst_resp_val", 64'(resp_val), 64'(0));
        checkOutput("rst_val_op", 64'(mul_val_op), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_resp_P", 64'(resp_P), 64'(0));
        checkOutput("rst_mul_B", 64'(mul_B), 64'(0));
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        manual_commit = 1'b1;
        tick();
        manual_commit = 1'b0;
        tick();
        checkOutput("late_commit_busy", 64'(busy), 64'(0));
        checkOutput("late_commit_resp_val", 64'(resp_val), 64'(0));

        // Back-pressure on requester 2 while requester 0 keeps asking.
        mul_lat = 2;
        req_A = '0;
        req_B = '0;
        req_A[2*8 +: 8]   = 8'd9;
        req_B[2*32 +: 32] = 32'd11;
        req_A[0 +: 8]     = 8'd1;
        req_B[0 +: 32]    = 32'd1;
        req_val = 4'b0100;
        tick();
        req_val = 4'b0001;
        k = 0;
        while (resp_val == '0 && k < 50) begin
            tick();
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_resp_P", 64'(resp_P), 64'(99));
            checkOutput("bp_resp_val", 64'(resp_val), 64'(4'b0100));
            checkOutput("bp_req_rdy", 64'(req_rdy), 64'(0));
            tick();
        end
        resp_rdy = 4'b0100;
        tick();
        resp_rdy = '0;
        req_val = '0;
        #1;
        checkOutput("bp_released", 64'(busy), 64'(0));

        // Reset while waiting on a multiplier that never commits.
        mul_lat = 0;
        req_A[1*8 +: 8]   = 8'd5;
        req_B[1*32 +: 32] = 32'd6;
        req_val = 4'b0010;
        tick();
        req_val = '0;
        tick();
        tick();
        checkOutput("midop_busy", 64'(busy), 64'(1));
        reset = 1'b0;
        #1;
        checkOutput("async_busy", 64'(busy), 64'(0));
        checkOutput("async_mul_A", 64'(mul_A), 64'(0));
        checkOutput("async_mul_B", 64'(mul_B), 64'(0));
        checkOutput("async_resp_val", 64'(resp_val), 64'(0));
        checkOutput("async_req_rdy", 64'(req_rdy), 64'(0));
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("post_reset_resp_val", 64'(resp_val), 64'(0));
        end
        req_val = 4'b1001;
        #1;
        checkOutput("rr_after_reset", 64'(req_rdy), 64'(4'b0001));
        req_val = '0;
        tick();

        // All requesters active: grants rotate 0,1,2,3,0.
        mul_lat = 2;
        for (int i = 0; i < 4; i++) begin
            req_A[i*8 +: 8]   = 8'(i + 2);
            req_B[i*32 +: 32] = 32'(100 * (i + 1));
        end
        req_val = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            rr_exp = 4'b1 << g;
            checkOutput("rr_grant", 64'(req_rdy), 64'(rr_exp));
            k = 0;
            tick();
            while (resp_val == '0 && k < 50) begin
                tick();
                k++;
            end
            checkOutput("rr_resp_val", 64'(resp_val), 64'(rr_exp));
            checkOutput("rr_resp_P", 64'(resp_P), 64'(rr_p[g]));
            resp_rdy = rr_exp;
            tick();
            resp_rdy = '0;
            if (n == 4) req_val = '0;
        end
        tick();
        checkOutput("final_idle", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/imul_arbiter.md
Name: imul_arbiter

Overview:
- Shares one iterative 8x32 integer multiplier among N_REQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Starts the multiplier with a one-cycle val_op pulse, waits for its commit pulse, then returns the 40-bit product to the granted requester over a valid/ready response channel.
- Adds a zero-operand bypass and a commit timeout that flags an error.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- A_W, 8, operand A width.
- B_W, 32, operand B width.
- P_W, 40, product width; must equal A_W+B_W.
- TIMEOUT, 64, maximum cycles in WAIT before aborting (>=2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- req_val  in  N_REQ  per-requester operation valid.
- req_rdy  out  N_REQ  per-requester accept; one-hot or zero.
- req_A  in  N_REQ*A_W  flattened A operands; requester i at [i*A_W +: A_W].
- req_B  in  N_REQ*B_W  flattened B operands.
- resp_val  out  N_REQ  per-requester response valid; one-hot or zero.
- resp_rdy  in  N_REQ  per-requester response accept.
- resp_P  out  P_W  product, shared by all requesters.
- resp_err  out  1  response is a timeout abort.
- mul_A  out  A_W  multiplier operand A.
- mul_B  out  B_W  multiplier operand B.
- mul_val_op  out  1  multiplier start pulse.
- mul_commit  in  1  multiplier done pulse.
- mul_P  in  P_W  multiplier product; valid in the commit cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the rr pointer to 0.
  - req_rdy, resp_val, mul_val_op, resp_err and busy are 0.
  - resp_P, mul_A and mul_B are 0.
  - Reset asserted mid-operation abandons the operation; no response is issued. Any multiplier commit arriving later is ignored in IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g is the first i with req_val[i]=1, searching from rr upward and wrapping modulo N_REQ.
  - req_rdy[g] is combinationally 1 in the same cycle. The transfer occurs at that edge.
  - On transfer, A and B are latched into mul_A/mul_B and g is stored.
  - If A==0 or B==0: resp_P<=0, resp_err<=0, next state RESP (multiplier not started).
  - Otherwise next state ISSUE.
  - No req_val set: stay in IDLE and all req_rdy are 0.
- ISSUE:
  - mul_val_op=1 for exactly this one cycle.
  - The timeout counter is cleared to 0. Next state WAIT.
- WAIT:
  - mul_A/mul_B stay stable. The counter increments each cycle.
  - On mul_commit=1: resp_P<=mul_P, resp_err<=0, next state RESP.
  - If the counter reaches TIMEOUT-1 without commit: resp_P<=0, resp_err<=1, next state RESP.
  - Commit in the same cycle as the timeout: commit wins and err=0.
- RESP:
  - resp_val[g]=1; resp_P and resp_err are held stable until accepted.
  - When resp_rdy[g]=1: rr<=(g+1) mod N_REQ, next state IDLE.
  - resp_rdy of other requesters is ignored.
- Throughput:
  - Minimum latency is 1 cycle for a zero-bypass request and 3 cycles for a multiplied request (issue, wait, response), plus the multiplier's own latency.
  - A new grant is possible in the cycle after response acceptance; no back-to-back overlap.
- req_rdy is 0 in every state except IDLE. A requester may drop req_val before being granted without effect.
- mul_commit outside WAIT is ignored.
- Arithmetic is unsigned; the full P_W-bit product is returned with no truncation.

Test Plan:
- Single requester 0: A=8'd3, B=32'd5, multiplier model commits 8 cycles after val_op.
  - Expect: req_rdy[0] in the req_val cycle; exactly one mul_val_op pulse.
  - Expect: resp_val[0] with resp_P=40'd15 and resp_err=0; busy low after resp_rdy.
- Max operands: A=8'hFF, B=32'hFFFFFFFF.
  - Expect: resp_P=40'hFE_FFFF_FF01.
- All N_REQ requesting continuously with distinct operands.
  - Expect grant order 0,1,2,3,0; each resp_P equals its own A*B; resp_val always one-hot.
- Zero bypass: A=0, B=32'h1234.
  - Expect: no mul_val_op; resp_val asserted the next cycle with P=0 and err=0.
- Timeout: model never commits, TIMEOUT=64.
  - Expect: resp_val 65 cycles after val_op with P=0 and err=1.
  - Expect: a late commit afterwards is ignored.
- Response back-pressure: hold resp_rdy=0 for 10 cycles.
  - Expect: resp_P stable and req_rdy all 0 throughout.
- Reset mid-operation: assert reset during WAIT.
  - Expect: all outputs 0 immediately (asynchronously); no response after release; rr=0.
